// File: rtl/fifo16_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo16_pkg
// Purpose  : Shared sizing constants for the 16-deep FIFO (also usable by the
//            matching LIFO stack and its bench).
// Contents : FIFO_W  - data word width
//            FIFO_AW - address width (depth = 2**FIFO_AW)
// Revision : 1.0 - initial release
// ============================================================================
package fifo16_pkg;
  localparam int FIFO_W  = 8;
  localparam int FIFO_AW = 4;
endpackage
`default_nettype wire

// File: rtl/fifo16_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo16_if
// Purpose  : Producer/consumer handshake and status bundle for fifo16.
// Signals  : push, pop, di  - requests and write data (driven by master)
//            dq             - show-ahead head word, 0 when empty
//            empty, full    - occupancy decodes
//            count          - occupancy 0..2**AW
//            ovf, unf       - sticky overflow / underflow flags
// Modports : master (producer/consumer side), slave (the FIFO)
// Revision : 1.0 - initial release
// ============================================================================
interface fifo16_if
  import fifo16_pkg::*;
#(
  parameter int W  = FIFO_W,
  parameter int AW = FIFO_AW
);
  logic          push;
  logic          pop;
  logic [W-1:0]  di;
  logic [W-1:0]  dq;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          ovf;
  logic          unf;

  modport master (
    output push, pop, di,
    input  dq, empty, full, count, ovf, unf
  );

  modport slave (
    input  push, pop, di,
    output dq, empty, full, count, ovf, unf
  );
endinterface
`default_nettype wire

// File: rtl/fifo16_ptr.sv
`default_nettype none
// ============================================================================
// Module   : fifo16_ptr
// Purpose  : AW-bit wrapping up-counter used for the FIFO write and read
//            pointers. Wraps naturally from 2**AW-1 back to 0.
// Ports    : CLK  - clock
//            INIT - synchronous active-high clear
//            ce   - count enable
//            ptr  - current pointer value (registered)
// Revision : 1.0 - initial release
// ============================================================================
module fifo16_ptr
  import fifo16_pkg::*;
#(
  parameter int AW = FIFO_AW
) (
  input  logic          CLK,
  input  logic          INIT,
  input  logic          ce,
  output logic [AW-1:0] ptr
);
  logic [AW-1:0] r_ptr;

  always_ff @(posedge CLK) begin
    if (INIT) begin
      r_ptr <= '0;
    end else if (ce) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  assign ptr = r_ptr;
endmodule
`default_nettype wire

// File: rtl/fifo16.sv
`default_nettype none
// ============================================================================
// Module   : fifo16
// Purpose  : 16-level x W-bit FIFO with show-ahead output, occupancy counter
//            and sticky overflow/underflow flags.
// Ports    : CLK  - clock, all state changes on the rising edge
//            INIT - synchronous active-high reset (pointers, count, flags)
//            bus  - fifo16_if.slave: push/pop/di in, dq/status out
// Revision : 1.0 - initial release
// ============================================================================
module fifo16
  import fifo16_pkg::*;
#(
  parameter int W  = FIFO_W,
  parameter int AW = FIFO_AW
) (
  input  logic     CLK,
  input  logic     INIT,
  fifo16_if.slave  bus
);
  localparam int          DEPTH        = 2 ** AW;
  localparam logic [AW:0] C_FULL_COUNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW:0]   r_count;
  logic          r_ovf;
  logic          r_unf;
  logic [AW-1:0] w_wr_ptr;
  logic [AW-1:0] w_rd_ptr;
  logic          w_empty;
  logic          w_full;
  logic          w_push_ok;
  logic          w_pop_ok;

  // Status decodes come only from the registered count.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == C_FULL_COUNT);

  // A push into a full queue is still accepted when a pop frees the head
  // slot in the same edge; the write then lands in the slot being vacated.
  assign w_push_ok = bus.push & (~w_full | bus.pop);
  assign w_pop_ok  = bus.pop & ~w_empty;

  fifo16_ptr #(.AW(AW)) u_wr_ptr (
    .CLK  (CLK),
    .INIT (INIT),
    .ce   (w_push_ok),
    .ptr  (w_wr_ptr)
  );

  fifo16_ptr #(.AW(AW)) u_rd_ptr (
    .CLK  (CLK),
    .INIT (INIT),
    .ce   (w_pop_ok),
    .ptr  (w_rd_ptr)
  );

  // Storage: synchronous write, asynchronous read; contents survive INIT.
  // INIT has priority over a push in the same cycle.
  always_ff @(posedge CLK) begin
    if (!INIT && w_push_ok) begin
      r_mem[w_wr_ptr] <= bus.di;
    end
  end

  // Occupancy up/down counter: moves only when exactly one side is accepted.
  always_ff @(posedge CLK) begin
    if (INIT) begin
      r_count <= '0;
    end else if (w_push_ok ^ w_pop_ok) begin
      if (w_push_ok) begin
        r_count <= r_count + 1'b1;
      end else begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Sticky error flags, cleared only by INIT.
  always_ff @(posedge CLK) begin
    if (INIT) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (bus.push && !w_push_ok) begin
        r_ovf <= 1'b1;
      end
      if (bus.pop && !w_pop_ok) begin
        r_unf <= 1'b1;
      end
    end
  end

  assign bus.dq    = w_empty ? '0 : r_mem[w_rd_ptr];
  assign bus.empty = w_empty;
  assign bus.full  = w_full;
  assign bus.count = r_count;
  assign bus.ovf   = r_ovf;
  assign bus.unf   = r_unf;
endmodule
`default_nettype wire
